key_search_controller: RTL

Top-level sequencer for RC4 brute-force key search. For each candidate key it runs the three S-memory phases in order: S-array initialisation, key-schedule shuffle, then message decryption. It stops on the first candidate whose plaintext passes the decryptor's character check, or when the key range is exhausted. It also owns the single S-memory port and multiplexes it to whichever phase engine is active.

---
 rtl/key_search_controller.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_search_controller.sv
// rtl/key_search_controller.sv - RC4 key search sequencer with S-memory port mux and phase watchdog
module key_search_controller #(
   parameter int KEY_WIDTH      = 24,
   parameter int RAM_WIDTH      = 8,
   parameter int RAM_LENGTH     = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [KEY_WIDTH-1:0]  key_first_i,
   input  logic [KEY_WIDTH-1:0]  key_last_i,
   output logic [KEY_WIDTH-1:0]  key_o,
   output logic                  init_start_o,
   output logic                  shuffle_start_o,
   output logic                  decrypt_start_o,
   input  logic                  init_finished_i,
   input  logic                  shuffle_finished_i,
   input  logic                  decrypt_finished_i,
   input  logic                  decrypt_success_i,
   input  logic [RAM_LENGTH-1:0] init_s_addr_i,
   input  logic [RAM_WIDTH-1:0]  init_s_in_i,
   input  logic                  init_s_wren_i,
   input  logic [RAM_LENGTH-1:0] shuffle_s_addr_i,
   input  logic [RAM_WIDTH-1:0]  shuffle_s_in_i,
   input  logic                  shuffle_s_wren_i,
   input  logic [RAM_LENGTH-1:0] decrypt_s_addr_i,
   input  logic [RAM_WIDTH-1:0]  decrypt_s_in_i,
   input  logic                  decrypt_s_wren_i,
   output logic [RAM_LENGTH-1:0] s_addr_o,
   output logic [RAM_WIDTH-1:0]  s_in_o,
   output logic                  s_wren_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  found_o,
   output logic                  timeout_o,
   output logic [KEY_WIDTH-1:0]  found_key_o
);

   localparam int WD_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      INIT_GO   = 4'd1,
      INIT_WAIT = 4'd2,
      SHUF_GO   = 4'd3,
      SHUF_WAIT = 4'd4,
      DEC_GO    = 4'd5,
      DEC_WAIT  = 4'd6,
      NEXT_KEY  = 4'd7,
      DONE      = 4'd8
   } state_t;

   state_t               state_q, state_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [KEY_WIDTH-1:0] key_last_q, key_last_d;
   logic [KEY_WIDTH-1:0] found_key_q, found_key_d;
   logic                 found_q, found_d;
   logic                 timeout_q, timeout_d;
   logic [WD_W-1:0]      wd_q, wd_d;
   logic                 start_q, start_dly_q, start_edge_q;
   logic                 wd_limit;

   assign wd_limit = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   // Start input: sample the pin, then register the rising edge so the FSM acts two edges later
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         start_q      <= 1'b0;
         start_dly_q  <= 1'b0;
         start_edge_q <= 1'b0;
      end else begin
         start_q      <= start_i;
         start_dly_q  <= start_q;
         start_edge_q <= start_q & ~start_dly_q;
      end
   end

   // FSM state, candidate key, result flags and watchdog counter
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         key_q       <= '0;
         key_last_q  <= '0;
         found_key_q <= '0;
         found_q     <= 1'b0;
         timeout_q   <= 1'b0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         key_last_q  <= key_last_d;
         found_key_q <= found_key_d;
         found_q     <= found_d;
         timeout_q   <= timeout_d;
         wd_q        <= wd_d;
      end
   end

   // Next-state logic: phase sequencing, key stepping, watchdog abort
   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      key_last_d  = key_last_q;
      found_key_d = found_key_q;
      found_d     = found_q;
      timeout_d   = timeout_q;
      wd_d        = wd_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_edge_q) begin
               key_d       = key_first_i;
               key_last_d  = key_last_i;
               found_d     = 1'b0;
               timeout_d   = 1'b0;
               found_key_d = '0;
               state_d     = (key_first_i > key_last_i) ? DONE : INIT_GO;
            end
         end
         INIT_GO: begin
            wd_d    = '0;
            state_d = INIT_WAIT;
         end
         INIT_WAIT: begin
            if (init_finished_i) begin
               state_d = SHUF_GO;
            end else if (wd_limit) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               found_d   = 1'b0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         SHUF_GO: begin
            wd_d    = '0;
            state_d = SHUF_WAIT;
         end
         SHUF_WAIT: begin
            if (shuffle_finished_i) begin
               state_d = DEC_GO;
            end else if (wd_limit) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               found_d   = 1'b0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         DEC_GO: begin
            wd_d    = '0;
            state_d = DEC_WAIT;
         end
         DEC_WAIT: begin
            // a finished pulse coinciding with the watchdog limit takes priority
            if (decrypt_finished_i) begin
               if (decrypt_success_i) begin
                  state_d     = DONE;
                  found_d     = 1'b1;
                  found_key_d = key_q;
               end else if (key_q == key_last_q) begin
                  state_d = DONE;
               end else begin
                  state_d = NEXT_KEY;
               end
            end else if (wd_limit) begin
               state_d   = DONE;
               timeout_d = 1'b1;
               found_d   = 1'b0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         NEXT_KEY: begin
            key_d   = key_q + KEY_WIDTH'(1);
            state_d = INIT_GO;
         end
         default: state_d = IDLE;
      endcase
   end

   // Engine start pulses and S-memory port ownership, decoded from the registered state
   always_comb begin
      init_start_o    = 1'b0;
      shuffle_start_o = 1'b0;
      decrypt_start_o = 1'b0;
      s_addr_o        = '0;
      s_in_o          = '0;
      s_wren_o        = 1'b0;
      case (state_q)
         INIT_GO, INIT_WAIT: begin
            init_start_o = (state_q == INIT_GO);
            s_addr_o     = init_s_addr_i;
            s_in_o       = init_s_in_i;
            s_wren_o     = init_s_wren_i;
         end
         SHUF_GO, SHUF_WAIT: begin
            shuffle_start_o = (state_q == SHUF_GO);
            s_addr_o        = shuffle_s_addr_i;
            s_in_o          = shuffle_s_in_i;
            s_wren_o        = shuffle_s_wren_i;
         end
         DEC_GO, DEC_WAIT: begin
            decrypt_start_o = (state_q == DEC_GO);
            s_addr_o        = decrypt_s_addr_i;
            s_in_o          = decrypt_s_in_i;
            s_wren_o        = decrypt_s_wren_i;
         end
         default: begin
         end
      endcase
   end

   assign key_o       = key_q;
   assign found_key_o = found_key_q;
   assign found_o     = found_q;
   assign timeout_o   = timeout_q;
   assign done_o      = (state_q == DONE);
   assign busy_o      = (state_q != IDLE) && (state_q != DONE);

endmodule
